// File: rtl/seq_adder.sv
// Digit-serial adder/subtractor: adds DIGIT bits per clock over WIDTH/DIGIT
// cycles and reports sum, carry-out and signed overflow with a done pulse.
module seq_adder #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             c_r;
   logic [CW-1:0]    cnt;
   logic [DIGIT:0]   dsum;
   logic [WIDTH-1:0] res_nxt;
   logic             msb_cin;
   logic             last;

   // Digit adder on the low operand bits; carry into the top bit of the digit
   // is recovered as a^b^s so it works for any DIGIT including 1.
   always_comb begin
      dsum    = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_r};
      msb_cin = a_r[DIGIT-1] ^ b_r[DIGIT-1] ^ dsum[DIGIT-1];
      last    = (cnt == CW'(N - 1));
   end

   // Partial result holds only the N-1 completed digits; the final digit is
   // merged directly into the output on the completing edge.
   if (N > 1) begin : g_multi
      logic [WIDTH-DIGIT-1:0] res;

      // Result shift register, new digit enters at the top
      always_ff @(posedge clk) begin
         if (rst)
            res <= '0;
         else if (state == IDLE && start)
            res <= '0;
         else if (state == RUN)
            res <= res_nxt[WIDTH-1:DIGIT];
      end

      assign res_nxt = {dsum[DIGIT-1:0], res};
   end else begin : g_single
      assign res_nxt = dsum[DIGIT-1:0];
   end

   // Control FSM, operand/carry registers and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum      <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
         a_r      <= '0;
         b_r      <= '0;
         c_r      <= 1'b0;
         cnt      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_r   <= A;
                  b_r   <= sub ? ~B : B;
                  c_r   <= sub ? 1'b1 : cin;
                  cnt   <= '0;
                  state <= RUN;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               a_r <= a_r >> DIGIT;
               b_r <= b_r >> DIGIT;
               c_r <= dsum[DIGIT];
               cnt <= cnt + CW'(1);
               if (last) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  sum      <= res_nxt;
                  carry    <= dsum[DIGIT];
                  overflow <= msb_cin ^ dsum[DIGIT];
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_adder.sv
// Directed bench for seq_adder: 16-bit/4-bit-digit and 8-bit/1-bit-digit builds.
module tb_seq_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, sub, cin;
   logic [15:0] a, b;
   logic        busy, done, carry, overflow;
   logic [15:0] sum;

   logic        start8, sub8, cin8;
   logic [7:0]  a8, b8;
   logic        busy8, done8, carry8, overflow8;
   logic [7:0]  sum8;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   seq_adder #(.WIDTH(16), .DIGIT(4)) u16 (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .A(a), .B(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .carry(carry), .overflow(overflow)
   );

   seq_adder #(.WIDTH(8), .DIGIT(1)) u8 (
      .clk(clk), .rst(rst), .start(start8), .sub(sub8), .A(a8), .B(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .carry(carry8), .overflow(overflow8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one 16-bit operation and return at the done cycle (cyc = edges after acceptance)
   task automatic do_op(input logic [15:0] ia, input logic [15:0] ib, input logic is, input logic ic,
                        output int cyc, output bit to);
      a = ia; b = ib; sub = is; cin = ic; start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 0;
      to  = 1'b0;
      while (!done && cyc < 40) begin
         tick();
         cyc++;
      end
      if (!done) to = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; a = 16'h1234; b = 16'h1111; sub = 1'b0; cin = 1'b1;
      start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; cin8 = 1'b0;
      tick(); tick();
      tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
      tests++; if (done !== 1'b0)     begin fails++; $display("FAIL reset_done got %b want 0", done); end
      tests++; if (sum !== 16'h0000)  begin fails++; $display("FAIL reset_sum got %h want 0000", sum); end
      tests++; if (carry !== 1'b0)    begin fails++; $display("FAIL reset_carry got %b want 0", carry); end
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", overflow); end
      tests++; if (busy8 !== 1'b0)    begin fails++; $display("FAIL reset_busy8 got %b want 0", busy8); end
      start = 1'b0; start8 = 1'b0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_add();
      int cyc; bit to;
      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, cyc, to);
      tests++; if (to || cyc != 4) begin fails++; $display("FAIL add_latency got %0d want 4", cyc); end
      tests++; if (sum !== 16'h0000) begin fails++; $display("FAIL add_wrap_sum got %h want 0000", sum); end
      tests++; if (carry !== 1'b1)   begin fails++; $display("FAIL add_wrap_carry got %b want 1", carry); end
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL add_wrap_ovf got %b want 0", overflow); end
      tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL add_busy_in_done got %b want 0", busy); end
      tick();
      tests++; if (done !== 1'b0)    begin fails++; $display("FAIL done_pulse_width got %b want 0", done); end
      tests++; if (sum !== 16'h0000 || carry !== 1'b1) begin fails++; $display("FAIL result_hold got %h/%b want 0000/1", sum, carry); end

      do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, cyc, to);
      tests++; if (to || sum !== 16'h8000) begin fails++; $display("FAIL add_ovf_sum got %h want 8000", sum); end
      tests++; if (carry !== 1'b0)    begin fails++; $display("FAIL add_ovf_carry got %b want 0", carry); end
      tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL add_ovf_ovf got %b want 1", overflow); end
      tick();

      do_op(16'h1234, 16'h0FCD, 1'b0, 1'b1, cyc, to);
      tests++; if (to || sum !== 16'h2202 || carry !== 1'b0 || overflow !== 1'b0)
         begin fails++; $display("FAIL add_cin got %h/%b/%b want 2202/0/0", sum, carry, overflow); end
      tick();
   endtask

   task automatic test_sub();
      int cyc; bit to;
      do_op(16'h0005, 16'h0007, 1'b1, 1'b1, cyc, to);
      tests++; if (to || sum !== 16'hFFFE) begin fails++; $display("FAIL sub_neg_sum got %h want fffe", sum); end
      tests++; if (carry !== 1'b0 || overflow !== 1'b0) begin fails++; $display("FAIL sub_neg_flags got %b/%b want 0/0", carry, overflow); end
      tick();
      do_op(16'h8000, 16'h0001, 1'b1, 1'b0, cyc, to);
      tests++; if (to || sum !== 16'h7FFF) begin fails++; $display("FAIL sub_ovf_sum got %h want 7fff", sum); end
      tests++; if (carry !== 1'b1 || overflow !== 1'b1) begin fails++; $display("FAIL sub_ovf_flags got %b/%b want 1/1", carry, overflow); end
      tick();
   endtask

   task automatic test_busy_ignore();
      int cyc; int dones;
      a = 16'h0100; b = 16'h0023; sub = 1'b0; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      a = 16'hAAAA; b = 16'h5555; sub = 1'b1; cin = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 2; dones = 0;
      while (!done && cyc < 40) begin tick(); cyc++; end
      tests++; if (!done || cyc != 4) begin fails++; $display("FAIL ignore_latency got %0d want 4", cyc); end
      tests++; if (sum !== 16'h0123) begin fails++; $display("FAIL ignore_sum got %h want 0123", sum); end
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done) dones++;
      end
      tests++; if (dones != 0) begin fails++; $display("FAIL ignore_extra_done got %0d want 0", dones); end
   endtask

   task automatic test_back_to_back();
      int cyc; bit to;
      do_op(16'h1111, 16'h2222, 1'b0, 1'b0, cyc, to);
      tests++; if (to || sum !== 16'h3333) begin fails++; $display("FAIL b2b_first got %h want 3333", sum); end
      a = 16'h4000; b = 16'h0001; sub = 1'b1; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept got %b want 1", busy); end
      cyc = 0;
      while (!done && cyc < 40) begin tick(); cyc++; end
      tests++; if (!done || cyc != 4) begin fails++; $display("FAIL b2b_latency got %0d want 4", cyc); end
      tests++; if (sum !== 16'h3FFF || carry !== 1'b1 || overflow !== 1'b0)
         begin fails++; $display("FAIL b2b_second got %h/%b/%b want 3fff/1/0", sum, carry, overflow); end
      tick();
   endtask

   task automatic test_rst_mid();
      int cyc; bit to; int dones;
      a = 16'h0F0F; b = 16'h0101; sub = 1'b0; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++; if (busy !== 1'b0 || done !== 1'b0 || sum !== 16'h0000)
         begin fails++; $display("FAIL rst_mid got busy=%b done=%b sum=%h want 0/0/0000", busy, done, sum); end
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done) dones++;
      end
      tests++; if (dones != 0) begin fails++; $display("FAIL rst_mid_done got %0d want 0", dones); end
      do_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, cyc, to);
      tests++; if (to || cyc != 4 || sum !== 16'h1010)
         begin fails++; $display("FAIL rst_restart got %h in %0d want 1010 in 4", sum, cyc); end
      tick();
   endtask

   task automatic test_width8();
      int busy_cyc; int n;
      a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b0; cin8 = 1'b1; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      busy_cyc = 0; n = 0;
      while (!done8 && n < 40) begin
         if (busy8) busy_cyc++;
         tick();
         n++;
      end
      tests++; if (!done8 || busy_cyc != 8) begin fails++; $display("FAIL w8_busy got %0d want 8", busy_cyc); end
      tests++; if (sum8 !== 8'h00 || carry8 !== 1'b1 || overflow8 !== 1'b0)
         begin fails++; $display("FAIL w8_result got %h/%b/%b want 00/1/0", sum8, carry8, overflow8); end
      tick();
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_busy_ignore();
      test_back_to_back();
      test_rst_mid();
      test_width8();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
